multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multicycle successor to the single-cycle opcode decoder. Sequences each MIPS instruction over 3-5+ cycles, driving the shared datapath (one memory, one ALU, PC/IR registers) from a Moore FSM. Handles a memory-ready handshake with a timeout, and flags illegal opcodes. Sits between the instruction register opcode field and the multicycle datapath control inputs.

Parameters:
ALUOPW, 3, width of alu_op, in the existing encoding: R=010, add=011, sub/beq=100, and=111, or=101, slt=001
ENABLE_IMM, 1, 1 = decode addi/andi/ori/slti; 0 = treat them as illegal
TIMEOUT_CYCLES, 255, maximum number of cycles to wait for mem_ready in one memory state (must be ≥1)
CNTW, 8, width of the wait counter (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; sampled only in DECODE
mem_ready  in  1  memory access complete this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
iord  out  1  0 = PC addresses memory; 1 = ALUOut addresses memory
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load IR
mem_to_reg  out  1  write-back source: 1 = MDR, 0 = ALUOut
reg_dst  out  1  1 = rd, 0 = rt
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
alu_op  out  ALUOPW  ALU operation class
pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
illegal_op  out  1  one-cycle pulse on an undecodable opcode
mem_timeout  out  1  sticky error; FSM halted
instr_done  out  1  one-cycle pulse in the final state of each instruction
state_o  out  4  current state encoding, for debug

Behaviour:
- Moore FSM. Outputs are combinational decodes of the registered state only, except for the mem_ready gating listed below. Outputs not listed for a state are 0.
- Reset: async, to FETCH with wait_cnt = 0 and mem_timeout = 0. Reset output values are therefore FETCH values: mem_read=1, alu_src_b=01, alu_op=011, all others 0 (pc_write and ir_write stay 0 because mem_ready is gated).
- FETCH (0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=011, pc_source=00. ir_write and pc_write are asserted equal to mem_ready. If mem_ready=1, go to DECODE; otherwise stay.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=011 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000/001100/001101/001010 -> IMMEX if ENABLE_IMM=1
  - any other opcode -> illegal_op=1 for this cycle, next state FETCH. No register or memory write occurs; PC has already advanced.
- MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=011. Go to MEMRD for lw, MEMWR for sw. The opcode is held stable by the IR.
- MEMRD (3): mem_read=1, iord=1. Go to MEMWB when mem_ready=1.
- MEMWB (4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Go to FETCH.
- MEMWR (5): mem_write=1, iord=1. When mem_ready=1: instr_done=1 and go to FETCH.
- EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=010. Go to RWB.
- RWB (7): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Go to FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=100, pc_write_cond=1, pc_source=01, instr_done=1. Go to FETCH.
- JUMP (9): pc_write=1, pc_source=10, instr_done=1. Go to FETCH.
- IMMEX (10): alu_src_a=1, alu_src_b=10, alu_op per opcode: addi=011, andi=111, ori=101, slti=001. Go to IMMWB.
- IMMWB (11): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Go to FETCH.
- HALT (15): all outputs 0 except mem_timeout=1. Stays in HALT until reset. Encodings 12-14 are unreachable and recover to FETCH.
- Cycle counts with zero-wait memory (mem_ready=1 on the first cycle):
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3
  - immediate: 4
  - illegal: 2
- Wait counter, in memory states FETCH, MEMRD and MEMWR:
  - wait_cnt increments on each cycle with mem_ready=0.
  - It clears to 0 on mem_ready=1 or on entry to any other state.
  - If mem_ready=0 and wait_cnt == TIMEOUT_CYCLES-1, go to HALT and set mem_timeout next cycle.
  - mem_ready=1 on that same cycle takes priority, and the access completes normally.
- Mid-instruction reset returns immediately (asynchronously) to FETCH. No partial write may be asserted after rst_n falls.

Decomposition:
- Shared package `mips_ctrl_pkg` holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI);
  - ALUOp localparams;
  - the state enum (4-bit), so that the datapath and the bench can decode state_o.
- No sub-module is required. The wait counter stays inline.

Test Plan:
- Reset then add (opcode 000000), mem_ready=1 always -> states 0,1,6,7; reg_write=1, reg_dst=1 in cycle 4; instr_done pulses once; total 4 cycles.
- lw with mem_ready low for 3 cycles in MEMRD -> FSM stays in MEMRD with mem_read=1, iord=1; MEMWB occurs after mem_ready rises; mem_to_reg=1 there; no timeout.
- beq followed by j -> BRANCH drives pc_write_cond=1, alu_op=100, pc_source=01; JUMP drives pc_write=1, pc_source=10; 3 cycles each.
- Opcode 111111 in DECODE, and addi with ENABLE_IMM=0 -> illegal_op pulse of one cycle, next state FETCH, no reg_write or mem_write.
- TIMEOUT_CYCLES=4 with mem_ready held at 0 in FETCH -> HALT entered after 4 wait cycles; mem_timeout=1 persists; only rst_n clears it. Repeat with mem_ready=1 on the 4th cycle -> no halt.
- rst_n asserted during MEMWR -> all outputs take FETCH values at once, mem_write=0, state_o=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALU
// operation classes and the controller state encoding exposed on state_o.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b100;
    localparam logic [2:0] ALU_AND   = 3'b111;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b001;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_HALT   = 4'd15
    } state_e;

    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore controller sequencing MIPS instructions over the shared multicycle
// datapath, with a bounded memory-ready wait and a sticky timeout halt.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALUOPW         = 3,
    parameter int unsigned ENABLE_IMM     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNTW           = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        opcode,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic              iord,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              mem_to_reg,
    output logic              reg_dst,
    output logic              reg_write,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [ALUOPW-1:0] alu_op,
    output logic [1:0]        pc_source,
    output logic              illegal_op,
    output logic              mem_timeout,
    output logic              instr_done,
    output logic [3:0]        state_o
);

    localparam logic [CNTW-1:0] WAIT_LAST = CNTW'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CNTW-1:0] wait_q, wait_d;
    logic            timeout_q, timeout_d;
    logic            op_legal;
    logic            mem_state;

    assign op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                      (opcode == OP_BEQ) || (opcode == OP_J) ||
                      ((ENABLE_IMM != 0) && is_imm_op(opcode));
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        timeout_d = timeout_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (!op_legal)                 state_d = S_FETCH;
                else if (opcode == OP_RTYPE)   state_d = S_EXEC;
                else if (opcode == OP_BEQ)     state_d = S_BRANCH;
                else if (opcode == OP_J)       state_d = S_JUMP;
                else if (is_imm_op(opcode))    state_d = S_IMMEX;
                else                           state_d = S_MEMADR;
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_IMMEX:  state_d = S_IMMWB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        // A completing access wins over the timeout on the final wait cycle.
        if (mem_state && !mem_ready) begin
            if (wait_q == WAIT_LAST) begin
                state_d   = S_HALT;
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = '0;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALUOPW'(ALU_ADD);
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                alu_op     = ALUOPW'(ALU_ADD);
                illegal_op = !op_legal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOPW'(ALU_ADD);
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOPW'(ALU_RTYPE);
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOPW'(ALU_SUB);
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ANDI: alu_op = ALUOPW'(ALU_AND);
                    OP_ORI:  alu_op = ALUOPW'(ALU_OR);
                    OP_SLTI: alu_op = ALUOPW'(ALU_SLT);
                    default: alu_op = ALUOPW'(ALU_ADD);
                endcase
            end
            S_IMMWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_timeout = timeout_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: directed instruction table, corner-case sequences and
// randomized instruction streams checked against an instruction-level model.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    localparam int TMO = 4;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
        logic [1:0] srcb;
        logic [2:0] aop;
        logic [1:0] psrc;
        logic       ill, tmo, done;
        logic [3:0] st;
    } cw_t;

    typedef struct {
        logic [5:0] op;
        int         fw;
        int         mw;
        int         exp_cycles;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic mem_ready = 1'b0;

    logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_timeout, instr_done;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    logic pc_write_b, pc_write_cond_b, iord_b, mem_read_b, mem_write_b, ir_write_b;
    logic mem_to_reg_b, reg_dst_b, reg_write_b, alu_src_a_b, illegal_op_b, mem_timeout_b, instr_done_b;
    logic [1:0] alu_src_b_b, pc_source_b;
    logic [2:0] alu_op_b;
    logic [3:0] state_o_b;

    cw_t act;
    assign act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                  illegal_op, mem_timeout, instr_done, state_o};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int end_cyc = -1;

    always #5 clk = ~clk;

    multicycle_control #(.ALUOPW(3), .ENABLE_IMM(1), .TIMEOUT_CYCLES(TMO), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .instr_done(instr_done), .state_o(state_o)
    );

    multicycle_control #(.ALUOPW(3), .ENABLE_IMM(0), .TIMEOUT_CYCLES(255), .CNTW(8)) dut_noimm (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b), .iord(iord_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .ir_write(ir_write_b),
        .mem_to_reg(mem_to_reg_b), .reg_dst(reg_dst_b), .reg_write(reg_write_b),
        .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b),
        .pc_source(pc_source_b), .illegal_op(illegal_op_b), .mem_timeout(mem_timeout_b),
        .instr_done(instr_done_b), .state_o(state_o_b)
    );

    function automatic bit legal_op(input logic [5:0] op);
        logic [5:0] known[9] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
        foreach (known[i]) if (known[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Control word the specification prescribes for each step of an instruction.
    function automatic cw_t spec_word(input state_e s, input logic mr, input logic [5:0] op);
        cw_t w = '0;
        w.st = s;
        case (s)
            S_FETCH:  begin w.mrd = 1; w.srcb = 2'b01; w.aop = 3'b011; w.irw = mr; w.pcw = mr; end
            S_DECODE: begin w.srcb = 2'b11; w.aop = 3'b011; w.ill = !legal_op(op); end
            S_MEMADR: begin w.srca = 1; w.srcb = 2'b10; w.aop = 3'b011; end
            S_MEMRD:  begin w.mrd = 1; w.iord = 1; end
            S_MEMWB:  begin w.rwr = 1; w.m2r = 1; w.done = 1; end
            S_MEMWR:  begin w.mwr = 1; w.iord = 1; w.done = mr; end
            S_EXEC:   begin w.srca = 1; w.aop = 3'b010; end
            S_RWB:    begin w.rwr = 1; w.rdst = 1; w.done = 1; end
            S_BRANCH: begin w.srca = 1; w.aop = 3'b100; w.pcwc = 1; w.psrc = 2'b01; w.done = 1; end
            S_JUMP:   begin w.pcw = 1; w.psrc = 2'b10; w.done = 1; end
            S_IMMEX:  begin
                w.srca = 1; w.srcb = 2'b10;
                w.aop = (op == OP_ANDI) ? 3'b111 : (op == OP_ORI) ? 3'b101 :
                        (op == OP_SLTI) ? 3'b001 : 3'b011;
            end
            S_IMMWB:  begin w.rwr = 1; w.done = 1; end
            S_HALT:   w.tmo = 1;
            default:  ;
        endcase
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step(input state_e s, input logic mr, input logic [5:0] op);
        mem_ready = mr;
        opcode    = op;
        #1;
        chk($sformatf("word cyc%0d st%0d", cyc, s), 32'(act), 32'(spec_word(s, mr, op)));
        if (act.done || act.ill) end_cyc = cyc;
        @(negedge clk);
        cyc++;
    endtask

    task automatic rnd_step(input state_e s, input logic [5:0] op);
        step(s, 1'($urandom_range(0, 1)), op);
    endtask

    task automatic mem_phase(input state_e s, input int waits, input logic [5:0] op, output bit halted);
        halted = 0;
        for (int k = 0; k <= waits; k++) begin
            if (k == TMO) begin
                halted = 1;
                return;
            end
            step(s, k == waits, (s == S_FETCH) ? 6'($urandom) : op);
        end
    endtask

    task automatic do_reset();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_word", 32'(act), 32'(spec_word(S_FETCH, 1'b0, opcode)));
        chk("reset_noimm_state", 32'(state_o_b), 32'(S_FETCH));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Instruction-level model: the step sequence follows from the opcode class.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, output bit halted);
        mem_phase(S_FETCH, fw, op, halted);
        if (halted) return;
        rnd_step(S_DECODE, op);
        if (!legal_op(op)) return;
        if (op == OP_RTYPE) begin
            rnd_step(S_EXEC, op); rnd_step(S_RWB, op);
        end else if (op == OP_LW) begin
            rnd_step(S_MEMADR, op);
            mem_phase(S_MEMRD, mw, op, halted);
            if (!halted) rnd_step(S_MEMWB, op);
        end else if (op == OP_SW) begin
            rnd_step(S_MEMADR, op);
            mem_phase(S_MEMWR, mw, op, halted);
        end else if (op == OP_BEQ) begin
            rnd_step(S_BRANCH, op);
        end else if (op == OP_J) begin
            rnd_step(S_JUMP, op);
        end else begin
            rnd_step(S_IMMEX, op); rnd_step(S_IMMWB, op);
        end
    endtask

    task automatic after_halt();
        for (int i = 0; i < 3; i++) rnd_step(S_HALT, 6'($urandom));
        do_reset();
    endtask

    initial begin
        vec_t vecs[$];
        bit   halted;
        int   start;
        logic [5:0] ops[9] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};

        vecs.push_back('{OP_RTYPE, 0, 0, 4});
        vecs.push_back('{OP_LW,    0, 0, 5});
        vecs.push_back('{OP_LW,    0, 3, 8});
        vecs.push_back('{OP_SW,    0, 0, 4});
        vecs.push_back('{OP_SW,    2, 1, 7});
        vecs.push_back('{OP_BEQ,   0, 0, 3});
        vecs.push_back('{OP_J,     0, 0, 3});
        vecs.push_back('{OP_ADDI,  0, 0, 4});
        vecs.push_back('{OP_ANDI,  1, 0, 5});
        vecs.push_back('{OP_ORI,   0, 0, 4});
        vecs.push_back('{OP_SLTI,  0, 0, 4});
        vecs.push_back('{6'h3f,    0, 0, 2});
        vecs.push_back('{6'h01,    0, 0, 2});
        vecs.push_back('{OP_LW,    3, 0, 8});
        vecs.push_back('{OP_SW,    0, 3, 7});

        @(negedge clk);
        do_reset();

        foreach (vecs[i]) begin
            start   = cyc;
            end_cyc = -1;
            run_instr(vecs[i].op, vecs[i].fw, vecs[i].mw, halted);
            chk($sformatf("cycles vec%0d op%b", i, vecs[i].op), 32'(end_cyc - start + 1),
                32'(vecs[i].exp_cycles));
        end

        // Fetch starved of mem_ready: halt is sticky until reset.
        do_reset();
        mem_phase(S_FETCH, 10, 6'h00, halted);
        for (int i = 0; i < 5; i++) step(S_HALT, 1'b1, OP_RTYPE);
        do_reset();
        run_instr(OP_RTYPE, 0, 0, halted);

        // addi is illegal when immediates are disabled.
        do_reset();
        step(S_FETCH, 1'b1, OP_ADDI);
        mem_ready = 1'b0;
        opcode = OP_ADDI;
        #1;
        chk("imm_on_decode", 32'(act), 32'(spec_word(S_DECODE, 1'b0, OP_ADDI)));
        chk("noimm_illegal", 32'(illegal_op_b), 32'd1);
        chk("noimm_writes", 32'({reg_write_b, mem_write_b}), 32'd0);
        @(negedge clk);
        cyc++;
        #1;
        chk("noimm_back_to_fetch", 32'(state_o_b), 32'(S_FETCH));
        chk("noimm_pulse_one_cycle", 32'(illegal_op_b), 32'd0);
        chk("imm_on_immex", 32'(act), 32'(spec_word(S_IMMEX, 1'b0, OP_ADDI)));
        @(negedge clk);
        cyc++;

        // Reset mid-store drops the write immediately.
        do_reset();
        step(S_FETCH, 1'b1, OP_SW);
        step(S_DECODE, 1'b0, OP_SW);
        step(S_MEMADR, 1'b0, OP_SW);
        mem_ready = 1'b0;
        #1;
        chk("memwr_before_reset", 32'(act), 32'(spec_word(S_MEMWR, 1'b0, OP_SW)));
        rst_n = 1'b0;
        #1;
        chk("memwr_reset_word", 32'(act), 32'(spec_word(S_FETCH, 1'b0, OP_SW)));
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            int fw, mw, r;
            r  = $urandom_range(0, 9);
            op = (r < 9) ? ops[r] : 6'($urandom);
            fw = ($urandom_range(0, 15) == 0) ? TMO + $urandom_range(0, 2) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 11) == 0) ? TMO - 1 + $urandom_range(0, 2) : $urandom_range(0, 2);
            run_instr(op, fw, mw, halted);
            if (halted) after_halt();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
